// File: rtl/parity_frame_checker.sv
// parity_frame_checker
//   Receives 9-bit serial frames, LSB-first: data bits 0..7, then a parity bit.
//   It checks parity over all 9 bits and reports each completed frame with a
//   one-cycle pulse. It also keeps a saturating count of frames that failed.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset (highest priority)
//   bit_in       serial bit, qualified by bit_valid
//   bit_valid    bit_in is valid this cycle
//   abort        drop any partial frame; ignores bit_valid in the same cycle
//   err_clr      clear err_count
//   data_out     data byte of the last completed frame (held)
//   frame_valid  one-cycle pulse per completed frame
//   parity_err   parity result of the last completed frame (held)
//   busy         a partial frame (1..8 bits) is held
//   err_count    saturating count of frames with parity_err=1
module parity_frame_checker #(
    parameter int ODD  = 0,
    parameter int ERRW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            bit_in,
    input  logic            bit_valid,
    input  logic            abort,
    input  logic            err_clr,
    output logic [7:0]      data_out,
    output logic            frame_valid,
    output logic            parity_err,
    output logic            busy,
    output logic [ERRW-1:0] err_count
);

    localparam logic ODD_BIT = (ODD != 0);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t     state, state_nxt;
    logic [3:0] bit_cnt;
    logic [7:0] shreg;
    logic       par;

    logic take;       // a bit is accepted this cycle
    logic first;      // accepted bit starts a new frame
    logic last;       // accepted bit is the parity bit
    logic frame_bad;  // parity of the frame that completes this cycle

    always_comb begin
        take      = bit_valid & ~abort;
        first     = take && (bit_cnt == 4'd0);
        last      = take && (state == SHIFT) && (bit_cnt == 4'd8);
        frame_bad = ((par ^ bit_in) != ODD_BIT);

        state_nxt = state;
        case (state)
            IDLE:    if (take) state_nxt = SHIFT;
            SHIFT:   if (last) state_nxt = DONE;
            // A bit in the DONE cycle is bit 0 of the next frame.
            DONE:    state_nxt = take ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= 4'd0;
            shreg       <= 8'h00;
            par         <= 1'b0;
            data_out    <= 8'h00;
            frame_valid <= 1'b0;
            parity_err  <= 1'b0;
            err_count   <= '0;
        end else begin
            state       <= state_nxt;
            frame_valid <= 1'b0;

            if (abort) begin
                bit_cnt <= 4'd0;
                par     <= 1'b0;
            end else if (bit_valid) begin
                par <= first ? bit_in : (par ^ bit_in);
                if (last) begin
                    // shreg already holds all 8 data bits; bit_in is parity
                    bit_cnt     <= 4'd0;
                    data_out    <= shreg;
                    parity_err  <= frame_bad;
                    frame_valid <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    shreg   <= {bit_in, shreg[7:1]};
                end
            end

            // A clear that coincides with a failing frame still counts that frame.
            if (err_clr)
                err_count <= (last && frame_bad) ? ERRW'(1) : '0;
            else if (last && frame_bad && (err_count != '1))
                err_count <= err_count + ERRW'(1);
        end
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_parity_frame_checker.sv
// tb_parity_frame_checker
//   Directed bench for parity_frame_checker. Three instances share one
//   stimulus stream: u0 (even, 8-bit counter), u1 (even, 2-bit counter) and
//   u2 (odd parity). Outputs are sampled 1 time unit after each rising edge.
module tb_parity_frame_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, bit_in, bit_valid, abort, err_clr;
    logic [7:0] d0, d1, d2;
    logic       fv0, fv1, fv2, pe0, pe1, pe2, b0, b1, b2;
    logic [7:0] e0, e2;
    logic [1:0] e1;

    int checks = 0;
    int passed = 0;

    parity_frame_checker #(.ODD(0), .ERRW(8)) u0 (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .abort(abort), .err_clr(err_clr), .data_out(d0), .frame_valid(fv0),
        .parity_err(pe0), .busy(b0), .err_count(e0));

    parity_frame_checker #(.ODD(0), .ERRW(2)) u1 (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .abort(abort), .err_clr(err_clr), .data_out(d1), .frame_valid(fv1),
        .parity_err(pe1), .busy(b1), .err_count(e1));

    parity_frame_checker #(.ODD(1), .ERRW(8)) u2 (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .abort(abort), .err_clr(err_clr), .data_out(d2), .frame_valid(fv2),
        .parity_err(pe2), .busy(b2), .err_count(e2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One clock with a valid bit, optionally with abort / err_clr.
    task automatic send_bit(input logic b, input logic ab, input logic clr);
        bit_in = b; bit_valid = 1'b1; abort = ab; err_clr = clr;
        @(posedge clk);
        #1;
        bit_in = 1'b0; bit_valid = 1'b0; abort = 1'b0; err_clr = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p);
        for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0, 1'b0);
        send_bit(p, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] v;
        rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; abort = 1'b0; err_clr = 1'b0;
        idle(2);
        chk("rst data_out",    d0,  8'h00);
        chk("rst frame_valid", fv0, 1'b0);
        chk("rst parity_err",  pe0, 1'b0);
        chk("rst busy",        b0,  1'b0);
        chk("rst err_count",   e0,  8'd0);
        rst = 1'b0;
        idle(1);

        // 0x04 + parity 1: two ones, passes even, fails odd
        v = 8'h04;
        send_bit(v[0], 1'b0, 1'b0);
        chk("f04 busy after bit0", b0, 1'b1);
        for (int i = 1; i < 8; i++) send_bit(v[i], 1'b0, 1'b0);
        chk("f04 no pulse before parity", fv0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        chk("f04 frame_valid", fv0, 1'b1);
        chk("f04 data_out",    d0,  8'h04);
        chk("f04 parity_err",  pe0, 1'b0);
        chk("f04 err_count",   e0,  8'd0);
        chk("f04 busy done",   b0,  1'b0);
        chk("f04 odd parity_err", pe2, 1'b1);
        chk("f04 odd err_count",  e2,  8'd1);
        idle(1);
        chk("f04 pulse one cycle", fv0, 1'b0);
        chk("f04 data held",       d0,  8'h04);

        // 0x2B + parity 1: five ones, fails even, passes odd
        send_frame(8'h2B, 1'b1);
        chk("f2B frame_valid", fv0, 1'b1);
        chk("f2B data_out",    d0,  8'h2B);
        chk("f2B parity_err",  pe0, 1'b1);
        chk("f2B err_count",   e0,  8'd1);
        chk("f2B odd parity_err", pe2, 1'b0);
        chk("f2B odd err_count",  e2,  8'd1);
        idle(2);
        chk("f2B parity_err held", pe0, 1'b1);

        // 0x51 + parity 1 with 1..3 idle cycles between bits
        v = 8'h51;
        for (int i = 0; i < 8; i++) begin
            send_bit(v[i], 1'b0, 1'b0);
            idle(i % 3 + 1);
        end
        chk("f51 busy in gap",      b0,  1'b1);
        chk("f51 no pulse in gap",  fv0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        chk("f51 frame_valid", fv0, 1'b1);
        chk("f51 data_out",    d0,  8'h51);
        chk("f51 parity_err",  pe0, 1'b0);
        chk("f51 err_count",   e0,  8'd1);

        // back-to-back: 0x00/p0 then 0x55/p0 with no idle cycle
        send_frame(8'h00, 1'b0);
        chk("b2b1 frame_valid", fv0, 1'b1);
        chk("b2b1 data_out",    d0,  8'h00);
        chk("b2b1 parity_err",  pe0, 1'b0);
        v = 8'h55;
        send_bit(v[0], 1'b0, 1'b0);
        chk("b2b2 bit0 kept busy", b0,  1'b1);
        chk("b2b2 no pulse",       fv0, 1'b0);
        for (int i = 1; i < 8; i++) send_bit(v[i], 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        chk("b2b2 frame_valid", fv0, 1'b1);
        chk("b2b2 data_out",    d0,  8'h55);
        chk("b2b2 parity_err",  pe0, 1'b0);
        idle(1);

        // abort after 5 bits (abort cycle also carries a valid bit)
        repeat (5) send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        chk("abort busy",        b0,  1'b0);
        chk("abort no pulse",    fv0, 1'b0);
        chk("abort data held",   d0,  8'h55);
        send_frame(8'h80, 1'b1);
        chk("f80 frame_valid", fv0, 1'b1);
        chk("f80 data_out",    d0,  8'h80);
        chk("f80 parity_err",  pe0, 1'b0);
        chk("f80 err_count",   e0,  8'd1);
        idle(1);

        // abort coincident with the parity bit: frame discarded
        for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        chk("abort9 no pulse",  fv0, 1'b0);
        chk("abort9 data held", d0,  8'h80);
        chk("abort9 busy",      b0,  1'b0);
        chk("abort9 err held",  e0,  8'd1);
        send_frame(8'h04, 1'b1);
        chk("post abort9 frame_valid", fv0, 1'b1);
        chk("post abort9 data_out",    d0,  8'h04);

        // reset after 4 bits of a further frame, with a valid bit present
        repeat (4) send_bit(1'b1, 1'b0, 1'b0);
        rst = 1'b1; bit_valid = 1'b1; bit_in = 1'b1; abort = 1'b1; err_clr = 1'b1;
        idle(1);
        rst = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; abort = 1'b0; err_clr = 1'b0;
        chk("midrst busy",        b0,  1'b0);
        chk("midrst frame_valid", fv0, 1'b0);
        chk("midrst data_out",    d0,  8'h00);
        chk("midrst parity_err",  pe0, 1'b0);
        chk("midrst err_count",   e0,  8'd0);
        chk("midrst odd err_count", e2, 8'd0);
        idle(3);
        chk("midrst no late pulse", fv0, 1'b0);

        // saturation on the 2-bit counter
        for (int k = 1; k <= 4; k++) begin
            send_frame(8'h2B, 1'b1);
            chk("sat err_count w2", e1, (k < 4) ? k : 3);
            chk("sat err_count w8", e0, k);
        end
        for (int i = 0; i < 8; i++) send_bit(v[i] ^ 1'b0, 1'b0, 1'b0);  // 0x55: four ones
        send_bit(1'b1, 1'b0, 1'b1);                                     // bad parity + err_clr
        chk("clr+bad parity_err", pe1, 1'b1);
        chk("clr+bad err_count w2", e1, 2'd1);
        chk("clr+bad err_count w8", e0, 8'd1);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        chk("clr alone w2", e1, 2'd0);
        chk("clr alone w8", e0, 8'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/parity_frame_checker.md
PARITY_FRAME_CHECKER -- requirements
Module: parity_frame_checker

Interface
REQ-001 Parameter: ODD, default 0, parity sense (0 = even parity across 9 bits, 1 = odd parity across 9 bits).
REQ-002 Parameter: ERRW, default 8, width of the error counter.
REQ-003 Port: clk  input  1  single clock; all logic rising-edge triggered.
REQ-004 Port: rst  input  1  reset; synchronous, active-high.
REQ-005 Port: bit_in  input  1  serial frame bit; sampled only when bit_valid=1.
REQ-006 Port: bit_valid  input  1  qualifies bit_in for the current cycle.
REQ-007 Port: abort  input  1  discards any partial frame.
REQ-008 Port: err_clr  input  1  clears err_count.
REQ-009 Port: data_out  output  8  data bits of the last completed frame.
REQ-010 Port: frame_valid  output  1  one-cycle pulse; a frame has completed.
REQ-011 Port: parity_err  output  1  parity result of the last completed frame; valid while frame_valid=1 and held until the next frame completes.
REQ-012 Port: busy  output  1  high while a partial frame (1 to 8 bits) is held.
REQ-013 Port: err_count  output  ERRW  saturating count of frames that failed parity.

Function
REQ-014 Frame format: 9 bits, data bit 0 first, data bits 1-7 next, parity bit last.
REQ-015 The frame shall be checked over all 9 bits.
- ODD=0: the frame passes when the XOR of all 9 bits is 0.
- ODD=1: the frame passes when the XOR of all 9 bits is 1.
REQ-016 FSM states: IDLE, SHIFT, DONE.
- IDLE -> SHIFT on the first valid bit.
- SHIFT -> DONE on the 9th valid bit.
- DONE -> IDLE after one cycle, or DONE -> SHIFT when a valid bit is present in the DONE cycle.
REQ-017 A 4-bit bit counter shall increment on each valid bit and wrap to 0 after the 9th valid bit.
REQ-018 A running parity register shall XOR in every valid bit and restart from the new bit at each frame start.
REQ-019 A cycle with bit_valid=0 shall not advance the counter, the shift register or the parity register; gaps of any length are legal.
REQ-020 Frame-completion timing:
- data_out, parity_err and frame_valid shall update on the clock edge that samples the 9th valid bit.
- Latency from the 9th bit to frame_valid is 1 cycle.
REQ-021 frame_valid shall be high for exactly one cycle per completed frame.
REQ-022 data_out shall hold its value until the next frame completes.
REQ-023 Back-to-back frames: a valid bit in the DONE cycle is bit 0 of the next frame; no bit shall be lost.
REQ-024 abort=1 shall clear the counter and parity register and return the FSM to IDLE.
- No frame_valid shall be produced for the discarded frame.
- data_out, parity_err and err_count shall be unchanged.
- Any bit_valid in the same cycle shall be ignored.
REQ-025 abort in the same cycle as the 9th bit: abort wins; the frame is discarded.
REQ-026 err_count shall increment by 1 on each completed frame with parity_err=1 and saturate at 2^ERRW-1.
REQ-027 err_clr and a parity-error completion in the same cycle: err_count shall become 1.
REQ-028 err_clr alone shall set err_count to 0.
REQ-029 busy shall be 1 exactly when the FSM is in SHIFT.

Reset
REQ-030 rst=1 shall force, on the next clock edge:
- FSM to IDLE, bit counter to 0, parity register to 0;
- data_out=0x00, frame_valid=0, parity_err=0, busy=0, err_count=0.
REQ-031 rst shall take priority over abort, err_clr and bit_valid.
REQ-032 rst asserted mid-frame shall discard the partial frame with no frame_valid pulse.

Verification
REQ-033 ODD=0; bits of frame 0x04 with parity bit 1 (9'b1_0000_0100), each with bit_valid=1 -> one cycle after the 9th bit: frame_valid=1, data_out=0x04, parity_err=0, err_count=0.
REQ-034 ODD=0; frame 0x2B with parity bit 1 (four ones in data, five ones total) -> parity_err=1, data_out=0x2B, err_count=1.
REQ-035 Frame 0x51 with 1-3 idle cycles inserted between bits -> the same result as the gapless case; busy=1 between the first and 9th bit.
REQ-036 Two frames back-to-back with no idle cycle (0x00 with parity bit 0, then 0x55 with parity bit 0) -> two frame_valid pulses 9 cycles apart; data_out 0x00 then 0x55; both parity_err=0.
REQ-037 abort after 5 bits, then a full frame 0x80 with parity bit 1 -> a single frame_valid with data_out=0x80 and parity_err=0; rst applied after 4 bits of a further frame -> all outputs 0 and no pulse.
REQ-038 ERRW=2; four bad frames -> err_count 1, 2, 3, 3 (saturates); err_clr coincident with a fifth bad frame -> err_count=1.
